// File: rtl/find_max_pkg.sv
// Shared types and constants for the find_MAX operand-stream transmitter.
package find_max_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned TUPLE_W   = 35;

    // Bit offsets of each field inside a packed tuple.
    localparam int unsigned INSTR_LSB = 27;
    localparam int unsigned A_LSB     = 19;
    localparam int unsigned B_LSB     = 11;
    localparam int unsigned C_LSB     = 3;
    localparam int unsigned SEL_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BEAT,
        DONE
    } state_e;

    // Field order matches the offsets above: instr is the MSB field, sel the LSB field.
    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [SEL_W-1:0]  sel;
    } tuple_t;

endpackage

// File: rtl/find_max_tuple_fifo.sv
// Synchronous tuple FIFO with full/empty flags and an occupancy count.
module find_max_tuple_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 35,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];

    // A push on full is refused even if a pop frees a slot in the same cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/find_max_stim_tx.sv
// Transmit side of the find_MAX operand stream: queues tuples and, per command, emits
// start / count beats / done on registered outputs.
module find_max_stim_tx
    import find_max_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TUPLE_W    = 35,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_instr,
    input  logic [DATA_W-1:0] i_in_a,
    input  logic [DATA_W-1:0] i_in_b,
    input  logic [DATA_W-1:0] i_in_c,
    input  logic [SEL_W-1:0]  i_in_sel,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [CNT_W-1:0]  i_cmd_count,
    output logic              o_start,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data_a,
    output logic [DATA_W-1:0] o_data_b,
    output logic [DATA_W-1:0] o_data_c,
    output logic [DATA_W-1:0] o_instruction,
    output logic [SEL_W-1:0]  o_select,
    output logic              o_done,
    output logic              o_busy,
    output logic [LVL_W-1:0]  o_fifo_level
);

    state_e             r_state;
    state_e             w_state_d;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_d;
    logic [CNT_W-1:0]   r_beats_left;
    logic [CNT_W-1:0]   w_beats_d;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [TUPLE_W-1:0] w_wdata;
    logic [TUPLE_W-1:0] w_rdata;
    tuple_t             w_head;
    tuple_t             r_beat;
    logic               r_valid;

    assign w_wdata = {i_in_instr, i_in_a, i_in_b, i_in_c, i_in_sel};
    assign w_head  = w_rdata;

    find_max_tuple_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TUPLE_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_in_valid),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    // Next state; a pop is taken on the edge that enters each beat cycle so the popped
    // tuple is on the outputs during that beat cycle.
    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_beats_d = r_beats_left;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    w_state_d = START;
                    w_count_d = i_cmd_count;
                end
            end
            START: begin
                w_count_d = '0;
                if (r_count == '0) begin
                    w_state_d = DONE;
                end else begin
                    w_state_d = BEAT;
                    w_pop     = !w_empty;
                    w_beats_d = r_count - CNT_W'(w_pop);
                end
            end
            BEAT: begin
                if (r_beats_left == '0) begin
                    w_state_d = DONE;
                end else begin
                    w_pop     = !w_empty;
                    w_beats_d = r_beats_left - CNT_W'(w_pop);
                end
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // FSM state, latched count (non-zero only during START) and remaining beats.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_beats_left <= '0;
        end else begin
            r_state      <= w_state_d;
            r_count      <= w_count_d;
            r_beats_left <= w_beats_d;
        end
    end

    // Beat output register; zeroed on bubbles and outside transactions.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else if (w_pop) begin
            r_valid <= 1'b1;
            r_beat  <= w_head;
        end else begin
            r_valid <= 1'b0;
            r_beat  <= '0;
        end
    end

    assign o_in_ready    = !w_full;
    assign o_cmd_ready   = (r_state == IDLE);
    assign o_start       = (r_state == START);
    assign o_count       = r_count;
    assign o_done        = (r_state == DONE);
    assign o_busy        = (r_state != IDLE);
    assign o_valid       = r_valid;
    assign o_instruction = r_beat.instr;
    assign o_data_a      = r_beat.a;
    assign o_data_b      = r_beat.b;
    assign o_data_c      = r_beat.c;
    assign o_select      = r_beat.sel;

endmodule

// File: tb/tb_find_max_stim_tx.sv
// Bench for find_max_stim_tx: table of directed cycles, hand-written corner sequences and
// random traffic, all checked against a queue-based protocol model.
module tb_find_max_stim_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid, in_ready;
    logic [7:0] in_instr, in_a, in_b, in_c;
    logic [2:0] in_sel;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_count;
    logic       o_start, o_valid, o_done, o_busy;
    logic [2:0] o_count, o_select;
    logic [7:0] o_data_a, o_data_b, o_data_c, o_instruction;
    logic [3:0] o_fifo_level;

    always #5 clk = ~clk;

    find_max_stim_tx dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_instr    (in_instr),
        .i_in_a        (in_a),
        .i_in_b        (in_b),
        .i_in_c        (in_c),
        .i_in_sel      (in_sel),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_count   (cmd_count),
        .o_start       (o_start),
        .o_count       (o_count),
        .o_valid       (o_valid),
        .o_data_a      (o_data_a),
        .o_data_b      (o_data_b),
        .o_data_c      (o_data_c),
        .o_instruction (o_instruction),
        .o_select      (o_select),
        .o_done        (o_done),
        .o_busy        (o_busy),
        .o_fifo_level  (o_fifo_level)
    );

    typedef struct {
        logic       iv;
        logic [7:0] a;
        logic       cv;
        logic [2:0] cc;
        logic       st;
        logic [2:0] cnt;
        logic       v;
        logic [7:0] ea;
        logic       dn;
        logic       bz;
        logic [3:0] lvl;
    } vec_t;

    vec_t vecs[12];

    int n_err = 0;
    int n_chk = 0;
    int n_beats = 0;
    int n_bubbles = 0;

    // Protocol model: queue of accepted tuples plus transaction phase
    // (0 idle, 1 start cycle, 2 beat cycles, 3 done cycle).
    logic [34:0] q[$];
    int m_ph = 0;
    int m_cnt = 0;
    int m_left = 0;

    function automatic vec_t mk(input int iv, input int a, input int cv, input int cc,
                                input int st, input int cnt, input int v, input int ea,
                                input int dn, input int bz, input int lvl);
        vec_t r;
        r.iv = iv[0]; r.a = a[7:0]; r.cv = cv[0]; r.cc = cc[2:0];
        r.st = st[0]; r.cnt = cnt[2:0]; r.v = v[0]; r.ea = ea[7:0];
        r.dn = dn[0]; r.bz = bz[0]; r.lvl = lvl[3:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        in_valid  = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic set_push(input logic [7:0] a);
        in_valid = 1'b1;
        in_instr = 8'h01;
        in_a     = a;
        in_b     = 8'h00;
        in_c     = 8'h00;
        in_sel   = 3'd0;
    endtask

    // Advance one clock; at the following falling edge update the model and compare.
    task automatic tick();
        logic [34:0] exp_t;
        logic        beat;
        logic        acc_push;
        int          nph;
        @(negedge clk);
        acc_push = in_valid && (q.size() < 8);
        beat = 1'b0;
        nph = m_ph;
        case (m_ph)
            0: begin
                if (cmd_valid) begin
                    nph = 1;
                    m_cnt = int'(cmd_count);
                end
            end
            1: begin
                if (m_cnt == 0) nph = 3;
                else begin
                    nph = 2;
                    m_left = m_cnt;
                    beat = (q.size() > 0);
                end
            end
            2: begin
                if (m_left == 0) nph = 3;
                else beat = (q.size() > 0);
            end
            default: nph = 0;
        endcase
        exp_t = '0;
        if (beat) begin
            exp_t = q.pop_front();
            m_left--;
        end
        if (acc_push) q.push_back({in_instr, in_a, in_b, in_c, in_sel});
        m_ph = nph;

        if (o_valid) n_beats++;
        if (o_busy && !o_start && !o_done && !o_valid) n_bubbles++;

        check("start", o_start, m_ph == 1);
        check("count", o_count, (m_ph == 1) ? m_cnt : 0);
        check("valid", o_valid, beat);
        check("beat_data", {o_instruction, o_data_a, o_data_b, o_data_c, o_select}, exp_t);
        check("done", o_done, m_ph == 3);
        check("busy", o_busy, m_ph != 0);
        check("cmd_ready", cmd_ready, m_ph == 0);
        check("fifo_level", o_fifo_level, q.size());
        check("in_ready", in_ready, q.size() < 8);
    endtask

    // Call right after a falling edge (or at time 0).
    task automatic reset_dut();
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("rst_start", o_start, 0);
        check("rst_count", o_count, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data", {o_instruction, o_data_a, o_data_b, o_data_c, o_select}, 0);
        check("rst_done", o_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_level", o_fifo_level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cmd_ready", cmd_ready, 1);
        q.delete();
        m_ph = 0;
        m_cnt = 0;
        m_left = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget && m_ph != 0; i++) tick();
        tick();
        check("idle_busy", o_busy, 0);
    endtask

    initial begin
        int b0;
        logic prev_done;

        // Transaction of 3, then a zero-count transaction with one tuple left queued.
        vecs[0]  = mk(1, 10, 0, 0,  0, 0, 0, 0,  0, 0, 1);
        vecs[1]  = mk(1, 20, 0, 0,  0, 0, 0, 0,  0, 0, 2);
        vecs[2]  = mk(1, 30, 0, 0,  0, 0, 0, 0,  0, 0, 3);
        vecs[3]  = mk(0, 0,  1, 3,  1, 3, 0, 0,  0, 1, 3);
        vecs[4]  = mk(0, 0,  0, 0,  0, 0, 1, 10, 0, 1, 2);
        vecs[5]  = mk(0, 0,  0, 0,  0, 0, 1, 20, 0, 1, 1);
        vecs[6]  = mk(0, 0,  0, 0,  0, 0, 1, 30, 0, 1, 0);
        vecs[7]  = mk(0, 0,  0, 0,  0, 0, 0, 0,  1, 1, 0);
        vecs[8]  = mk(1, 40, 0, 0,  0, 0, 0, 0,  0, 0, 1);
        vecs[9]  = mk(0, 0,  1, 0,  1, 0, 0, 0,  0, 1, 1);
        vecs[10] = mk(0, 0,  0, 0,  0, 0, 0, 0,  1, 1, 1);
        vecs[11] = mk(0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 1);

        in_instr = '0; in_a = '0; in_b = '0; in_c = '0; in_sel = '0; cmd_count = '0;
        drive_idle();
        reset_dut();

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].iv) set_push(vecs[i].a);
            else in_valid = 1'b0;
            cmd_valid = vecs[i].cv;
            cmd_count = vecs[i].cc;
            tick();
            check($sformatf("v%0d_start", i), o_start, vecs[i].st);
            check($sformatf("v%0d_count", i), o_count, vecs[i].cnt);
            check($sformatf("v%0d_valid", i), o_valid, vecs[i].v);
            check($sformatf("v%0d_a", i), o_data_a, vecs[i].ea);
            check($sformatf("v%0d_done", i), o_done, vecs[i].dn);
            check($sformatf("v%0d_busy", i), o_busy, vecs[i].bz);
            check($sformatf("v%0d_level", i), o_fifo_level, vecs[i].lvl);
        end
        drive_idle();

        // Four beats with only one queued; the rest arrive later, forcing bubbles.
        b0 = n_beats;
        n_bubbles = 0;
        cmd_valid = 1'b1;
        cmd_count = 3'd4;
        tick();
        cmd_valid = 1'b0;
        cmd_count = 3'd7;
        repeat (5) tick();
        for (int k = 0; k < 3; k++) begin
            set_push(8'(50 + 10 * k));
            tick();
        end
        drive_idle();
        run_until_idle(20);
        check("t2_beats", n_beats - b0, 4);
        check("t2_bubble_seen", n_bubbles > 0, 1);

        // Overfill: the ninth push is refused.
        for (int k = 0; k < 9; k++) begin
            set_push(8'(100 + k));
            tick();
        end
        drive_idle();
        check("t4_full_level", o_fifo_level, 8);
        check("t4_full_ready", in_ready, 0);
        cmd_valid = 1'b1;
        cmd_count = 3'd7;
        tick();
        cmd_valid = 1'b0;
        run_until_idle(30);
        check("t4_leftover", o_fifo_level, 1);

        // Reset during the second beat of a five-beat transaction.
        for (int k = 0; k < 4; k++) begin
            set_push(8'(200 + k));
            tick();
        end
        drive_idle();
        cmd_valid = 1'b1;
        cmd_count = 3'd5;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        reset_dut();
        tick();
        for (int k = 0; k < 2; k++) begin
            set_push(8'(220 + k));
            tick();
        end
        drive_idle();
        cmd_valid = 1'b1;
        cmd_count = 3'd2;
        tick();
        cmd_valid = 1'b0;
        run_until_idle(20);

        // Command held high: each start must be preceded by a non-done cycle.
        prev_done = 1'b0;
        cmd_valid = 1'b1;
        cmd_count = 3'd1;
        for (int k = 0; k < 30; k++) begin
            set_push(8'($urandom));
            in_b = 8'($urandom);
            tick();
            if (o_start) check("t6_gap", prev_done, 0);
            prev_done = o_done;
        end
        drive_idle();
        run_until_idle(20);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_instr  = 8'($urandom);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_c      = 8'($urandom);
            in_sel    = 3'($urandom);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_count = 3'($urandom);
            tick();
        end
        drive_idle();
        run_until_idle(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
